// File: rtl/clut_rle_encoder_if.sv
// Pixel stream handshake bundle for the CLUT7 RLE encoder.
//   src_pixel/src_write -> encoder, src_strobe <- encoder (pixel accepted)
//   dst_pixel/dst_write <- encoder, dst_strobe -> encoder (byte accepted)
// slave  : the encoder side
// master : the producer/consumer side (pixel source and byte sink)
interface clut_rle_encoder_if;
   logic [7:0] src_pixel;
   logic       src_write;
   logic       src_strobe;
   logic [7:0] dst_pixel;
   logic       dst_write;
   logic       dst_strobe;

   modport slave (
      input  src_pixel, src_write, dst_strobe,
      output src_strobe, dst_pixel, dst_write
   );

   modport master (
      output src_pixel, src_write, dst_strobe,
      input  src_strobe, dst_pixel, dst_write
   );
endinterface

// File: rtl/clut_rle_encoder.sv
// CLUT7 run-length encoder. Accepts one line of 7-bit CLUT indices and emits
// the CD-i RLE byte stream: single pixel {0,p}, or run {1,p} + count byte
// (1..MAX_RUN, 0 = repeat to end of line).
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   st           line length select (1: LINE_ST, 0: LINE_NORMAL), taken at line start
//   passthrough  1: dst mirrors src combinationally, encoder held idle
//   bus          src/dst pixel handshake (slave side)
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ACCUM       | accepting pixels, growing the current run
// EMIT_CODE   | presenting run code byte {1,p}
// EMIT_COUNT  | presenting run count byte (0 when run reaches end of line)
// EMIT_SINGLE | presenting single pixel byte {0,p}
module clut_rle_encoder #(
   parameter int LINE_NORMAL = 384,
   parameter int LINE_ST     = 360,
   parameter int MAX_RUN     = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 st,
   input  logic                 passthrough,
   clut_rle_encoder_if.slave    bus
);

   typedef enum logic [1:0] {ACCUM, EMIT_CODE, EMIT_COUNT, EMIT_SINGLE} state_t;

   localparam logic [8:0] NORMAL_M1 = 9'(LINE_NORMAL - 1);
   localparam logic [8:0] ST_M1     = 9'(LINE_ST - 1);
   localparam logic [8:0] MAX_RUN_L = 9'(MAX_RUN);
   localparam logic [7:0] MAX_RUN_B = 8'(MAX_RUN);

   state_t     state, state_nxt;
   logic [6:0] run_pix, run_pix_nxt;
   logic [8:0] run_len, run_len_nxt;
   logic       run_vld, run_vld_nxt;
   logic       run_eol, run_eol_nxt;
   logic [6:0] pend_pix, pend_pix_nxt;
   logic       pend_vld, pend_vld_nxt;
   logic       pend_eol, pend_eol_nxt;
   logic [8:0] pix_left, pix_left_nxt;

   logic [7:0] cnt;
   logic [8:0] rem;
   logic [6:0] q;

   assign q   = bus.src_pixel[6:0];
   assign cnt = (run_len > MAX_RUN_L) ? MAX_RUN_B : run_len[7:0];
   assign rem = run_len - {1'b0, cnt};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ACCUM;
         run_pix  <= '0;
         run_len  <= '0;
         run_vld  <= 1'b0;
         run_eol  <= 1'b0;
         pend_pix <= '0;
         pend_vld <= 1'b0;
         pend_eol <= 1'b0;
         pix_left <= '0;
      end else begin
         state    <= state_nxt;
         run_pix  <= run_pix_nxt;
         run_len  <= run_len_nxt;
         run_vld  <= run_vld_nxt;
         run_eol  <= run_eol_nxt;
         pend_pix <= pend_pix_nxt;
         pend_vld <= pend_vld_nxt;
         pend_eol <= pend_eol_nxt;
         pix_left <= pix_left_nxt;
      end
   end

   always_comb begin
      logic last;
      logic done;
      state_nxt    = state;
      run_pix_nxt  = run_pix;
      run_len_nxt  = run_len;
      run_vld_nxt  = run_vld;
      run_eol_nxt  = run_eol;
      pend_pix_nxt = pend_pix;
      pend_vld_nxt = pend_vld;
      pend_eol_nxt = pend_eol;
      pix_left_nxt = pix_left;
      last         = (pix_left == 9'd1);
      done         = 1'b0;

      if (passthrough) begin
         state_nxt    = ACCUM;
         run_len_nxt  = '0;
         run_vld_nxt  = 1'b0;
         run_eol_nxt  = 1'b0;
         pend_vld_nxt = 1'b0;
         pend_eol_nxt = 1'b0;
         pix_left_nxt = '0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (bus.src_write) begin
                  pix_left_nxt = (pix_left == 9'd0) ? (st ? ST_M1 : NORMAL_M1)
                                                    : pix_left - 9'd1;
                  if (!run_vld) begin
                     run_pix_nxt = q;
                     run_len_nxt = 9'd1;
                     run_vld_nxt = 1'b1;
                     if (last) begin
                        run_eol_nxt = 1'b1;
                        state_nxt   = EMIT_SINGLE;
                     end
                  end else if (q == run_pix) begin
                     run_len_nxt = run_len + 9'd1;
                     if (last) begin
                        run_eol_nxt = 1'b1;
                        state_nxt   = EMIT_CODE;
                     end
                  end else begin
                     // old run goes out first; a differing last pixel rides in pending
                     pend_pix_nxt = q;
                     pend_vld_nxt = 1'b1;
                     pend_eol_nxt = last;
                     run_eol_nxt  = 1'b0;
                     state_nxt    = (run_len == 9'd1) ? EMIT_SINGLE : EMIT_CODE;
                  end
               end
            end
            EMIT_CODE: begin
               if (bus.dst_strobe) state_nxt = EMIT_COUNT;
            end
            EMIT_COUNT: begin
               if (bus.dst_strobe) begin
                  if (run_eol) begin
                     done = 1'b1;
                  end else begin
                     run_len_nxt = rem;
                     if (rem >= 9'd2)      state_nxt = EMIT_CODE;
                     else if (rem == 9'd1) state_nxt = EMIT_SINGLE;
                     else                  done = 1'b1;
                  end
               end
            end
            EMIT_SINGLE: begin
               if (bus.dst_strobe) done = 1'b1;
            end
            default: state_nxt = ACCUM;
         endcase

         if (done) begin
            if (pend_vld) begin
               run_pix_nxt  = pend_pix;
               run_len_nxt  = 9'd1;
               run_vld_nxt  = 1'b1;
               run_eol_nxt  = pend_eol;
               pend_vld_nxt = 1'b0;
               pend_eol_nxt = 1'b0;
               state_nxt    = pend_eol ? EMIT_SINGLE : ACCUM;
            end else begin
               run_vld_nxt = 1'b0;
               run_len_nxt = '0;
               run_eol_nxt = 1'b0;
               state_nxt   = ACCUM;
            end
         end
      end
   end

   // reset gates the outputs directly since ACCUM would otherwise echo src_write
   always_comb begin
      bus.src_strobe = 1'b0;
      bus.dst_write  = 1'b0;
      bus.dst_pixel  = '0;
      if (reset_n) begin
         if (passthrough) begin
            bus.src_strobe = bus.dst_strobe;
            bus.dst_write  = bus.src_write;
            bus.dst_pixel  = bus.src_pixel;
         end else begin
            unique case (state)
               ACCUM:       bus.src_strobe = bus.src_write;
               EMIT_CODE:   begin bus.dst_write = 1'b1; bus.dst_pixel = {1'b1, run_pix}; end
               EMIT_COUNT:  begin bus.dst_write = 1'b1; bus.dst_pixel = run_eol ? 8'h00 : cnt; end
               EMIT_SINGLE: begin bus.dst_write = 1'b1; bus.dst_pixel = {1'b0, run_pix}; end
               default:     bus.src_strobe = 1'b0;
            endcase
         end
      end
   end

endmodule
